// File: rtl/m_wbio_ctrl_if.sv
// rtl/m_wbio_ctrl_if.sv - Wishbone I/O bus bundle between core master port and one-hot slaves.
interface m_wbio_ctrl_if #(
  parameter int NSLAVE = 4
);
  logic                   m_CYC_I;
  logic                   m_STB_I;
  logic                   m_WE_I;
  logic [31:0]            m_ADR_I;
  logic                   m_ACK_O;
  logic [31:0]            m_DAT_O;
  logic [NSLAVE-1:0]      s_STB_O;
  logic                   s_WE_O;
  logic [NSLAVE-1:0]      s_ACK_I;
  logic [32*NSLAVE-1:0]   s_DAT_I;

  modport slave (
    input  m_CYC_I, m_STB_I, m_WE_I, m_ADR_I, s_ACK_I, s_DAT_I,
    output m_ACK_O, m_DAT_O, s_STB_O, s_WE_O
  );

  modport master (
    output m_CYC_I, m_STB_I, m_WE_I, m_ADR_I, s_ACK_I, s_DAT_I,
    input  m_ACK_O, m_DAT_O, s_STB_O, s_WE_O
  );
endinterface

// File: rtl/m_wbio_ctrl.sv
// rtl/m_wbio_ctrl.sv - I/O page decoder issuing one strobe per access, with timeout and sticky error status.
module m_wbio_ctrl #(
  parameter int         NSLAVE     = 4,
  parameter int         SLVBASEBIT = 2,
  parameter int         TIMEOUT    = 15,
  parameter logic [4:0] IOPAGE     = 5'b01100
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  m_wbio_ctrl_if.slave bus,
  input  logic         clr_err_I,
  output logic         err_O,
  output logic [7:0]   err_cnt_O,
  output logic [31:0]  err_adr_O
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t            state;
  logic [NSLAVE-1:0] sel_q;
  logic [CW-1:0]     cnt;

  logic [NSLAVE-1:0] sel;
  logic              page, valid, req, hit, err_now;
  logic [31:0]       rd_dat;

  assign sel   = bus.m_ADR_I[SLVBASEBIT+NSLAVE-1:SLVBASEBIT];
  assign page  = (bus.m_ADR_I[31:27] == IOPAGE);
  assign valid = page && $onehot(sel);
  assign req   = bus.m_CYC_I && bus.m_STB_I;
  assign hit   = |(bus.s_ACK_I & sel_q);

  // Writes are not registered so the slave samples WE together with its strobe.
  assign bus.s_WE_O = bus.m_WE_I;

  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < NSLAVE; k++) begin
      if (sel_q[k]) rd_dat = rd_dat | bus.s_DAT_I[32*k +: 32];
    end
  end

  assign err_now = req && (((state == IDLE) && !valid) ||
                           ((state == ACTIVE) && !hit && (cnt == CNT_LAST)));

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state       <= IDLE;
      sel_q       <= '0;
      cnt         <= '0;
      bus.s_STB_O <= '0;
      bus.m_ACK_O <= 1'b0;
      bus.m_DAT_O <= '0;
      err_O       <= 1'b0;
      err_cnt_O   <= '0;
      err_adr_O   <= '0;
    end else begin
      bus.m_ACK_O <= 1'b0;
      bus.m_DAT_O <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            if (valid) begin
              sel_q       <= sel;
              cnt         <= '0;
              bus.s_STB_O <= sel;
              state       <= ACTIVE;
            end else begin
              bus.m_ACK_O <= 1'b1;
              state       <= DONE;
            end
          end
        end
        ACTIVE: begin
          if (!req) begin
            bus.s_STB_O <= '0;
            state       <= IDLE;
          end else if (hit) begin
            bus.m_ACK_O <= 1'b1;
            bus.m_DAT_O <= rd_dat;
            bus.s_STB_O <= '0;
            state       <= DONE;
          end else if (cnt == CNT_LAST) begin
            bus.m_ACK_O <= 1'b1;
            bus.s_STB_O <= '0;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus.s_STB_O <= '0;
          state       <= IDLE;
        end
        default: begin
          bus.s_STB_O <= '0;
          state       <= IDLE;
        end
      endcase

      // A fault in the clearing cycle restarts the count at one rather than being lost.
      if (err_now) begin
        err_O     <= 1'b1;
        err_adr_O <= bus.m_ADR_I;
        if (clr_err_I)                err_cnt_O <= 8'd1;
        else if (err_cnt_O != 8'hFF)  err_cnt_O <= err_cnt_O + 8'd1;
      end else if (clr_err_I) begin
        err_O     <= 1'b0;
        err_cnt_O <= '0;
        err_adr_O <= '0;
      end
    end
  end
endmodule
